// File: rtl/seg7_pkg.sv
// Shared encodings, digit count and active-low hex glyph table for the debug display.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    typedef enum logic [2:0] {
        MODE_PC    = 3'd0,
        MODE_INSTR = 3'd1,
        MODE_REG   = 3'd2,
        MODE_ADDR  = 3'd3,
        MODE_DATA  = 3'd4
    } disp_mode_e;

    localparam logic [2:0] MODE_BLANK_MIN = 3'd5;

    // Bit order {g,f,e,d,c,b,a}, active low; dp is added by the display stage.
    localparam logic [6:0] GLYPH_TABLE [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] glyph(input logic [3:0] nibble);
        return GLYPH_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Hex nibble to active-low 7-segment glyph {g,f,e,d,c,b,a}.
// Purely combinational, zero latency, no flow control.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    assign segs = glyph(nibble);

endmodule

// File: rtl/seg7_debug_display.sv
// Debug word select, per-frame snapshot and multiplexed 8-digit active-low 7-segment drive.
// an/seg register one cycle after each scan tick; reg_sel registers one cycle; no backpressure.
module seg7_debug_display
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 100000,
    parameter int REG_HOLD = 100000000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [2:0]  disp_mode,
    input  logic        auto_scan,
    input  logic [4:0]  reg_sel_sw,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic [31:0] reg_data,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    output logic [4:0]  reg_sel,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HOLD_W = (REG_HOLD > 1) ? $clog2(REG_HOLD) : 1;
    localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);

    logic [DIV_W-1:0]  div_cnt;
    logic [2:0]        dig_idx;
    logic [31:0]       snapshot;
    logic              blank;
    logic [HOLD_W-1:0] hold_cnt;
    logic [4:0]        auto_idx;

    logic              tick;
    logic              hold_wrap;
    logic [31:0]       sel_word;
    logic [3:0]        cur_nib;
    logic [6:0]        cur_glyph;
    logic              dp_n;

    assign tick      = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign hold_wrap = (hold_cnt == HOLD_W'(REG_HOLD - 1));
    assign cur_nib   = snapshot[{dig_idx, 2'b00} +: 4];
    assign dp_n      = ~(auto_scan && (dig_idx == LAST_DIGIT));

    always_comb begin
        sel_word = '0;
        case (disp_mode)
            MODE_PC:    sel_word = pc_in;
            MODE_INSTR: sel_word = instr_in;
            MODE_REG:   sel_word = reg_data;
            MODE_ADDR:  sel_word = addr_in;
            MODE_DATA:  sel_word = data_in;
            default:    sel_word = '0;
        endcase
    end

    seg7_hex_decoder u_hex_decoder (
        .nibble (cur_nib),
        .segs   (cur_glyph)
    );

    // The output registers latch the slot being left, so digit 7 of the old snapshot
    // is shown on the same tick the next frame's snapshot is captured.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            div_cnt  <= '0;
            dig_idx  <= '0;
            snapshot <= '0;
            blank    <= 1'b0;
            an       <= 8'hFF;
            seg      <= 8'hFF;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
            if (tick) begin
                dig_idx <= dig_idx + 1'b1;
                an      <= ~(8'b1 << dig_idx);
                seg     <= blank ? 8'hFF : {dp_n, cur_glyph};
                if (dig_idx == LAST_DIGIT) begin
                    snapshot <= sel_word;
                    blank    <= (disp_mode >= MODE_BLANK_MIN);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hold_cnt <= '0;
            auto_idx <= '0;
            reg_sel  <= '0;
        end else begin
            reg_sel <= auto_scan ? auto_idx : reg_sel_sw;
            if (auto_scan) begin
                hold_cnt <= hold_wrap ? '0 : hold_cnt + 1'b1;
                if (hold_wrap)
                    auto_idx <= auto_idx + 1'b1;
            end else begin
                hold_cnt <= '0;
                auto_idx <= '0;
            end
        end
    end

endmodule
